// File: rtl/spi_frame_gen.sv
// SPI-style frame generator: serializes FRAME_LEN-bit words onto ce/sdo, MSB first,
// with a GAP_LEN-cycle idle gap. Define SPI_FRAME_LSB_FIRST_EN for LSB-first order.
module spi_frame_gen #(
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned GAP_LEN   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FRAME_LEN-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 abort,
    output logic                 ce,
    output logic                 sdo,
    output logic                 done,
    output logic                 aborted
);

    localparam int unsigned      CNT_W    = $clog2(FRAME_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [3:0]       GAP_LAST = 4'(GAP_LEN - 1);

    if (FRAME_LEN < 2 || FRAME_LEN > 64 || GAP_LEN < 1 || GAP_LEN > 15) begin : g_param_check
        $error("spi_frame_gen: FRAME_LEN or GAP_LEN out of range");
    end

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    state_e               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [3:0]           r_gap_cnt;
    logic [FRAME_LEN-1:0] r_shift;
    logic                 r_ce;
    logic                 r_sdo;
    logic                 r_done;
    logic                 r_aborted;
    logic                 r_ready;

    // r_shift holds the bits not yet driven; sdo is registered one bit ahead of it.
    logic [FRAME_LEN-1:0] w_load;
    logic                 w_load_bit;
    logic [FRAME_LEN-1:0] w_next;
    logic                 w_next_bit;

`ifdef SPI_FRAME_LSB_FIRST_EN
    assign w_load_bit = in_data[0];
    assign w_load     = {1'b0, in_data[FRAME_LEN-1:1]};
    assign w_next_bit = r_shift[0];
    assign w_next     = {1'b0, r_shift[FRAME_LEN-1:1]};
`else
    assign w_load_bit = in_data[FRAME_LEN-1];
    assign w_load     = {in_data[FRAME_LEN-2:0], 1'b0};
    assign w_next_bit = r_shift[FRAME_LEN-1];
    assign w_next     = {r_shift[FRAME_LEN-2:0], 1'b0};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
            r_shift   <= '0;
            r_ce      <= 1'b0;
            r_sdo     <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_state <= StShift;
                        r_shift <= w_load;
                        r_sdo   <= w_load_bit;
                        r_ce    <= 1'b1;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                    end
                end
                StShift: begin
                    // Abort wins over normal completion on the last bit.
                    if (abort || (r_cnt == CNT_LAST)) begin
                        r_state   <= StGap;
                        r_ce      <= 1'b0;
                        r_sdo     <= 1'b0;
                        r_shift   <= '0;
                        r_gap_cnt <= '0;
                        r_done    <= ~abort;
                        r_aborted <= abort;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_shift <= w_next;
                        r_sdo   <= w_next_bit;
                    end
                end
                StGap: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= StIdle;
                        r_ready <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_ce    <= 1'b0;
                    r_sdo   <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready = r_ready;
    assign ce       = r_ce;
    assign sdo      = r_sdo;
    assign done     = r_done;
    assign aborted  = r_aborted;

endmodule

// File: tb/tb_spi_frame_gen.sv
// Scoreboard bench for spi_frame_gen: stimulus pushes expected frames, a monitor
// rebuilds each ce-high burst from sdo and compares length, bits and end pulses.
module tb_spi_frame_gen;

    localparam int FL = 16;
    localparam int GL = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [FL-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          abort = 1'b0;
    logic          in_ready;
    logic          ce;
    logic          sdo;
    logic          done;
    logic          aborted;
    bit            prop_off = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          len;
        logic [63:0] bits;
        bit          done;
        bit          ab;
    } frame_t;

    frame_t exp_q[$];

    spi_frame_gen #(
        .FRAME_LEN(FL),
        .GAP_LEN  (GL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .abort   (abort),
        .ce      (ce),
        .sdo     (sdo),
        .done    (done),
        .aborted (aborted)
    );

    always #5 clk = ~clk;

    // Frame length: ce stays high FL cycles after a rise (burst continuity is checked
    // by the monitor's bit count).
    property p_frame_len;
        @(posedge clk) disable iff (rst || prop_off)
        $rose(ce) |-> ##FL !ce;
    endproperty

    a_frame_len: assert property (p_frame_len)
    else begin
        n_fail++;
        $display("FAIL frame_len_property: ce not low %0d cycles after rise at %0t", FL, $time);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] exp_bits(input logic [FL-1:0] d, input int n);
        logic [63:0] acc = '0;
        for (int k = 0; k < n; k++) begin
`ifdef SPI_FRAME_LSB_FIRST_EN
            acc = {acc[62:0], d[k]};
`else
            acc = {acc[62:0], d[FL-1-k]};
`endif
        end
        return acc;
    endfunction

    task automatic push(input int len, input logic [63:0] bits, input bit d, input bit a);
        frame_t f;
        f.len  = len;
        f.bits = bits;
        f.done = d;
        f.ab   = a;
        exp_q.push_back(f);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one word for one edge; caller guarantees in_ready is high.
    task automatic send(input logic [FL-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_idle: in_ready 0 after 100 cycles, required 1");
    endtask

    initial begin : monitor
        logic [63:0] acc;
        int          len;
        bit          prev_ce;
        frame_t      e;
        acc     = '0;
        len     = 0;
        prev_ce = 1'b0;
        forever begin
            @(negedge clk);
            if (ce) begin
                acc = {acc[62:0], sdo};
                len++;
                check("no_pulse_in_frame", 64'({done, aborted}), 64'd0);
            end else begin
                check("sdo_low_when_ce_low", 64'(sdo), 64'd0);
                if (prev_ce) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got %0d bits %0h, required none", len, acc);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_len", 64'(len), 64'(e.len));
                        check("frame_bits", acc, e.bits);
                        check("frame_done", 64'(done), 64'(e.done));
                        check("frame_aborted", 64'(aborted), 64'(e.ab));
                    end
                    acc = '0;
                    len = 0;
                end else begin
                    check("no_stray_pulse", 64'({done, aborted}), 64'd0);
                end
            end
            prev_ce = ce;
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int rise2;
        bit prev;
        bit go;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ce", 64'(ce), 64'd0);
        check("rst_sdo", 64'(sdo), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_aborted", 64'(aborted), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Basic frame: accept in cycle 0, ce 1..16, done in 17.
`ifdef SPI_FRAME_LSB_FIRST_EN
        push(16, 64'h0000_0000_0000_C3A5, 1'b1, 1'b0);
`else
        push(16, 64'h0000_0000_0000_A5C3, 1'b1, 1'b0);
`endif
        send(16'hA5C3);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("f1_ready_busy", 64'(in_ready), 64'd0);
                check("f1_ce_rise", 64'(ce), 64'd1);
            end
            if (c == 16) check("f1_ce_last", 64'(ce), 64'd1);
            if (c == 17) begin
                check("f1_ce_fall", 64'(ce), 64'd0);
                check("f1_done", 64'(done), 64'd1);
            end
            if (c == 18) begin
                check("f1_ready_back", 64'(in_ready), 64'd1);
                check("f1_done_once", 64'(done), 64'd0);
            end
        end
        wait_idle();

        // in_valid held across two words; second word only latched once idle.
        push(16, exp_bits(16'h1234, 16), 1'b1, 1'b0);
        push(16, exp_bits(16'hFEDC, 16), 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        tick();
        in_data = 16'hFEDC;
        rise2   = -1;
        prev    = 1'b1;
        for (int c = 1; c <= 60 && rise2 < 0; c++) begin
            @(negedge clk);
            if (!prev && ce) rise2 = c;
            prev = ce;
            go   = in_ready;
            tick();
            if (go) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("b2b_second_rise_cycle", 64'(rise2), 64'd19);
        wait_idle();

        // Abort in ce-high cycle 5.
        prop_off = 1'b1;
        push(5, exp_bits(16'hF0F0, 5), 1'b0, 1'b1);
        send(16'hF0F0);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_ce_low_cycle6", 64'(ce), 64'd0);
        wait_idle();

        // Abort coinciding with the final shift cycle.
        push(16, exp_bits(16'h3C69, 16), 1'b0, 1'b1);
        send(16'h3C69);
        repeat (15) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_last_ce", 64'(ce), 64'd0);
        check("abort_last_done", 64'(done), 64'd0);
        wait_idle();
        prop_off = 1'b0;

        // Abort during GAP is ignored.
        push(16, exp_bits(16'h8001, 16), 1'b1, 1'b0);
        send(16'h8001);
        repeat (16) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("gap_abort_ready", 64'(in_ready), 64'd1);
        check("gap_abort_no_pulse", 64'(aborted), 64'd0);

        // Abort while idle is ignored.
        abort = 1'b1;
        repeat (2) tick();
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_ce", 64'(ce), 64'd0);
        check("idle_abort_ready", 64'(in_ready), 64'd1);

        // Reset beats in_valid while idle.
        in_valid = 1'b1;
        in_data  = 16'h7777;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_vs_valid_ce", 64'(ce), 64'd0);
        check("rst_vs_valid_ready", 64'(in_ready), 64'd1);

        // Reset in ce-high cycle 8, together with in_valid and abort.
        prop_off = 1'b1;
        push(8, exp_bits(16'hFFFF, 8), 1'b0, 1'b0);
        send(16'hFFFF);
        repeat (7) tick();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h1111;
        abort    = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        abort    = 1'b0;
        @(negedge clk);
        check("midrst_ce", 64'(ce), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd1);
        check("midrst_sdo", 64'(sdo), 64'd0);
        repeat (3) @(negedge clk);
        prop_off = 1'b0;

        // Normal frame after mid-frame reset.
        push(16, exp_bits(16'h0001, 16), 1'b1, 1'b0);
        send(16'h0001);
        wait_idle();
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_frame_gen.md
SPI_FRAME_GEN -- requirements
Module: spi_frame_gen

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 16, meaning ce-high cycles per frame and data bits per word (legal range 2..64).
REQ-002 SHALL have parameter GAP_LEN, default 1, meaning minimum ce-low cycles after each frame in the GAP state (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic samples on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_data, input, FRAME_LEN bits: word to serialize.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a word.
REQ-008 SHALL have port abort, input, 1 bit: terminate the current frame early.
REQ-009 SHALL have port ce, output, 1 bit: frame enable to the downstream serial consumer.
REQ-010 SHALL have port sdo, output, 1 bit: serial data, valid while ce=1.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when a frame completes normally.
REQ-012 SHALL have port aborted, output, 1 bit: one-cycle pulse when a frame ends by abort.

Function
REQ-013 SHALL implement states IDLE, SHIFT and GAP; in_ready=1 only in IDLE.
REQ-014 SHALL accept a word when in_valid=1 and in_ready=1 at posedge N, latching in_data into a shift register and entering SHIFT; ce=1 from cycle N+1.
REQ-015 SHALL hold ce=1 for exactly FRAME_LEN consecutive cycles per normal frame, then drive ce=0.
REQ-016 SHALL present data bit FRAME_LEN-1-k on sdo in ce-high cycle k (MSB first, k=0..FRAME_LEN-1); sdo=0 whenever ce=0.
REQ-017 SHALL use a bit counter of width clog2(FRAME_LEN)+1 with no wrap inside a frame; on count FRAME_LEN-1, the next state is GAP.
REQ-018 SHALL pulse done=1 in the first GAP cycle after a normal frame.
REQ-019 SHALL stay in GAP for exactly GAP_LEN cycles with ce=0, then enter IDLE; back-to-back frames are therefore separated by at least GAP_LEN+1 ce-low cycles.
REQ-020 SHALL ignore in_valid and in_data while not in IDLE; no word is lost or latched.
REQ-021 SHALL, when abort=1 at a posedge in SHIFT, drive ce=0 the next cycle, enter GAP and pulse aborted=1 instead of done.
REQ-022 SHALL give abort priority if abort coincides with the final SHIFT cycle: the result is aborted=1, done=0, and ce low after FRAME_LEN cycles.
REQ-023 SHALL ignore abort in IDLE and GAP.
REQ-024 SHALL register all outputs (ce, sdo, done, aborted, in_ready) with no combinational input-to-output path.

Reset
REQ-025 SHALL, when rst=1 at a posedge, enter IDLE with ce=0, sdo=0, done=0, aborted=0 and in_ready=1 from the next cycle; the counter and shift register are cleared.
REQ-026 SHALL, on reset mid-frame, drop ce the next cycle without a done or aborted pulse or a GAP period.
REQ-027 SHALL give rst priority over in_valid and abort in the same cycle.

Configuration
REQ-028 SHALL, when macro SPI_FRAME_LSB_FIRST_EN is defined, shift LSB first (bit k in ce-high cycle k); otherwise MSB first per REQ-016; all timing is identical in both builds.

Verification
REQ-029 SHALL cover: in_data=16'hA5C3 accepted in cycle 0 -> ce=1 in cycles 1..16, sdo=1010_0101_1100_0011, ce=0 in cycle 17, done=1 in cycle 17.
REQ-030 SHALL cover: in_valid held high with two words -> second ce rise no earlier than cycle 19 (GAP_LEN=1), the first word's frame unaffected and the second latched only in IDLE.
REQ-031 SHALL cover: abort=1 in ce-high cycle 5 -> ce=0 in cycle 6, aborted=1 once, done never asserted.
REQ-032 SHALL cover: rst=1 in ce-high cycle 8 -> ce=0, in_ready=1 next cycle, and no done or aborted pulse.
REQ-033 SHALL cover: a concurrent property on posedge clk, !ce ##1 ce |-> ce[*FRAME_LEN] ##1 !ce, holds for all non-aborted, non-reset frames, including with SPI_FRAME_LSB_FIRST_EN defined (sdo 16'hA5C3 -> 1100_0011_1010_0101).
